// File: rtl/flight_state_model.sv
// Per-tick flight dynamics integrator: turns pilot control levels into throttle,
// heading, altitude and speed, with a GROUND/AIRBORNE/STALL phase machine.
module flight_state_model #(
  parameter int TICK_DIV      = 500000,
  parameter int TAKEOFF_SPEED = 150,
  parameter int STALL_SPEED   = 80,
  parameter int MAX_ALT       = 15000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        throttle_up,
  input  logic        throttle_down,
  input  logic        yaw_left,
  input  logic        yaw_right,
  input  logic        climb,
  input  logic        descend,
  input  logic        hold,
  output logic [6:0]  throttle,
  output logic [8:0]  heading,
  output logic [13:0] altitude,
  output logic [8:0]  speed,
  output logic [1:0]  phase,
  output logic        update
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX     = CW'(TICK_DIV - 1);
  localparam logic [8:0]    SPD_TAKEOFF = 9'(TAKEOFF_SPEED);
  localparam logic [8:0]    SPD_STALL   = 9'(STALL_SPEED);
  localparam logic [8:0]    SPD_RECOVER = 9'(STALL_SPEED + 10);
  localparam logic [14:0]   ALT_CEIL    = 15'(MAX_ALT);
  localparam logic [13:0]   ALT_MAX     = 14'(MAX_ALT);

  typedef enum logic [1:0] {
    PH_GROUND = 2'd0,
    PH_AIR    = 2'd1,
    PH_STALL  = 2'd2
  } phase_e;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    thr_q, thr_d;
  logic [8:0]    hdg_q, hdg_d;
  logic [13:0]   alt_q, alt_d;
  logic [8:0]    spd_q, spd_d;
  phase_e        phase_q, phase_d;
  logic          upd_q, upd_d;

  logic          tick;
  logic [8:0]    spd_tgt;
  logic [3:0]    rate;
  logic [14:0]   alt_up;
  logic [13:0]   alt_climb, alt_desc, alt_fall, alt_air;

  // Saturating altitude candidates, all from pre-tick values; alt_up is one bit
  // wider so the climb sum cannot wrap before the ceiling clamp.
  always_comb begin
    spd_tgt   = {thr_q, 2'b00};
    rate      = spd_q[8:5];
    alt_up    = {1'b0, alt_q} + {11'd0, rate};
    alt_climb = (alt_up > ALT_CEIL) ? ALT_MAX : alt_up[13:0];
    alt_desc  = (alt_q > {10'd0, rate}) ? alt_q - {10'd0, rate} : '0;
    alt_fall  = (alt_q > 14'd2) ? alt_q - 14'd2 : '0;
    if (climb && !descend)
      alt_air = alt_climb;
    else if (descend && !climb)
      alt_air = alt_desc;
    else
      alt_air = alt_q;
  end

  always_comb begin
    tick    = !hold && (cnt_q == CNT_MAX);
    cnt_d   = cnt_q;
    if (!hold)
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    upd_d   = tick;
    thr_d   = thr_q;
    hdg_d   = hdg_q;
    alt_d   = alt_q;
    spd_d   = spd_q;
    phase_d = phase_q;

    if (tick) begin
      if (throttle_up && !throttle_down && thr_q != 7'd100)
        thr_d = thr_q + 7'd1;
      else if (throttle_down && !throttle_up && thr_q != 7'd0)
        thr_d = thr_q - 7'd1;

      if (spd_q < spd_tgt)
        spd_d = spd_q + 9'd1;
      else if (spd_q > spd_tgt)
        spd_d = spd_q - 9'd1;

      // A stationary aircraft cannot turn.
      if (spd_q != 9'd0) begin
        if (yaw_right && !yaw_left)
          hdg_d = (hdg_q == 9'd359) ? 9'd0 : hdg_q + 9'd1;
        else if (yaw_left && !yaw_right)
          hdg_d = (hdg_q == 9'd0) ? 9'd359 : hdg_q - 9'd1;
      end

      unique case (phase_q)
        PH_GROUND: begin
          alt_d = '0;
          if (climb && spd_q >= SPD_TAKEOFF) begin
            alt_d   = {10'd0, rate};
            phase_d = PH_AIR;
          end
        end
        PH_AIR: begin
          if (spd_q < SPD_STALL) begin
            alt_d   = alt_fall;
            phase_d = PH_STALL;
          end else begin
            alt_d = alt_air;
            if (alt_air == '0)
              phase_d = PH_GROUND;
          end
        end
        PH_STALL: begin
          alt_d = alt_fall;
          if (alt_fall == '0)
            phase_d = PH_GROUND;
          else if (spd_q >= SPD_RECOVER)
            phase_d = PH_AIR;
        end
        default: begin
          alt_d   = '0;
          phase_d = PH_GROUND;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      thr_q   <= '0;
      hdg_q   <= '0;
      alt_q   <= '0;
      spd_q   <= '0;
      phase_q <= PH_GROUND;
      upd_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      thr_q   <= thr_d;
      hdg_q   <= hdg_d;
      alt_q   <= alt_d;
      spd_q   <= spd_d;
      phase_q <= phase_d;
      upd_q   <= upd_d;
    end
  end

  assign throttle = thr_q;
  assign heading  = hdg_q;
  assign altitude = alt_q;
  assign speed    = spd_q;
  assign phase    = phase_q;
  assign update   = upd_q;

endmodule

// File: tb/tb_flight_state_model.sv
// Scoreboard bench for flight_state_model: a per-tick reference model pushes
// expected values, a monitor pops and compares them on every update pulse.
module tb_flight_state_model;
  localparam int TD = 4;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        throttle_up = 0, throttle_down = 0, yaw_left = 0, yaw_right = 0;
  logic        climb = 0, descend = 0, hold = 0;
  logic [6:0]  throttle;
  logic [8:0]  heading;
  logic [13:0] altitude;
  logic [8:0]  speed;
  logic [1:0]  phase;
  logic        update;

  flight_state_model #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset_n(reset_n),
    .throttle_up(throttle_up), .throttle_down(throttle_down),
    .yaw_left(yaw_left), .yaw_right(yaw_right),
    .climb(climb), .descend(descend), .hold(hold),
    .throttle(throttle), .heading(heading), .altitude(altitude),
    .speed(speed), .phase(phase), .update(update)
  );

  always #5 clk = ~clk;

  typedef struct { int thr; int hdg; int alt; int spd; int ph; } exp_t;
  exp_t q[$];
  int m_thr, m_hdg, m_alt, m_spd, m_ph, m_cnt;
  int n_chk = 0, n_pass = 0, n_upd = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  // Reference model: plain integer arithmetic on the flight rules.
  task automatic model_tick();
    int up, dn, r, nthr, nspd, nhdg, nalt, nph;
    exp_t e;
    up   = (throttle_up && !throttle_down) ? 1 : 0;
    dn   = (throttle_down && !throttle_up) ? 1 : 0;
    nthr = clamp(m_thr + up - dn, 0, 100);
    nspd = (m_spd < m_thr * 4) ? m_spd + 1 : (m_spd > m_thr * 4) ? m_spd - 1 : m_spd;
    nhdg = m_hdg;
    if (m_spd > 0 && yaw_right && !yaw_left) nhdg = (m_hdg + 1) % 360;
    if (m_spd > 0 && yaw_left && !yaw_right) nhdg = (m_hdg + 359) % 360;
    r    = m_spd / 32;
    nalt = m_alt;
    nph  = m_ph;
    if (m_ph == 0) begin
      nalt = 0;
      if (climb && m_spd >= 150) begin nalt = r; nph = 1; end
    end else if (m_ph == 1) begin
      if (m_spd < 80) begin
        nalt = clamp(m_alt - 2, 0, 15000); nph = 2;
      end else begin
        if (climb && !descend) nalt = clamp(m_alt + r, 0, 15000);
        if (descend && !climb) nalt = clamp(m_alt - r, 0, 15000);
        if (nalt == 0) nph = 0;
      end
    end else begin
      nalt = clamp(m_alt - 2, 0, 15000);
      if (nalt == 0) nph = 0;
      else if (m_spd >= 90) nph = 1;
    end
    m_thr = nthr; m_spd = nspd; m_hdg = nhdg; m_alt = nalt; m_ph = nph;
    e.thr = nthr; e.hdg = nhdg; e.alt = nalt; e.spd = nspd; e.ph = nph;
    if (q.size() != 0) check("missed_update", q.size(), 0);
    q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_thr = 0; m_hdg = 0; m_alt = 0; m_spd = 0; m_ph = 0; m_cnt = 0;
        q.delete();
      end else if (!hold) begin
        if (m_cnt == TD - 1) begin m_cnt = 0; model_tick(); end
        else m_cnt++;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && update) begin
        n_upd++;
        if (q.size() == 0) check("spurious_update", int'(update), 0);
        else begin
          e = q.pop_front();
          check("throttle", int'(throttle), e.thr);
          check("heading", int'(heading), e.hdg);
          check("altitude", int'(altitude), e.alt);
          check("speed", int'(speed), e.spd);
          check("phase", int'(phase), e.ph);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic ctl(input bit tu, input bit tdn, input bit yl, input bit yr,
                     input bit cl, input bit de);
    throttle_up = tu; throttle_down = tdn; yaw_left = yl; yaw_right = yr;
    climb = cl; descend = de;
  endtask

  task automatic ticks(input int n);
    repeat (n * TD) @(negedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_throttle"}, int'(throttle), 0);
    check({tag, "_heading"}, int'(heading), 0);
    check({tag, "_altitude"}, int'(altitude), 0);
    check({tag, "_speed"}, int'(speed), 0);
    check({tag, "_phase"}, int'(phase), 0);
    check({tag, "_update"}, int'(update), 0);
  endtask

  initial begin
    int n0, a0, guard;
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    reset_n = 1'b1;

    // Idle with yaw_right held: no motion, heading stays 0, one update per 4 cycles.
    ctl(0, 0, 0, 1, 0, 0);
    n0 = n_upd;
    ticks(10);
    check("idle_updates", n_upd - n0, 10);
    check("idle_heading", int'(heading), 0);
    check("idle_speed", int'(speed), 0);

    // Throttle ramp and saturation; speed lags one tick.
    ctl(1, 0, 0, 0, 0, 0);
    ticks(100);
    check("thr_100", int'(throttle), 100);
    ticks(20);
    check("thr_sat", int'(throttle), 100);
    check("spd_lag", int'(speed), 119);
    ctl(1, 1, 0, 0, 0, 0);
    ticks(5);
    check("thr_both", int'(throttle), 100);
    ctl(0, 0, 0, 0, 0, 0);
    ticks(280);
    check("spd_max", int'(speed), 400);

    // Heading wrap both ways.
    ctl(0, 0, 1, 0, 0, 0);
    ticks(1);
    check("hdg_wrap_left", int'(heading), 359);
    ctl(0, 0, 0, 1, 0, 0);
    ticks(2);
    check("hdg_wrap_right", int'(heading), 1);

    // Slow to 160 then take off.
    ctl(0, 1, 0, 0, 0, 0);
    ticks(60);
    ctl(0, 0, 0, 0, 0, 0);
    ticks(300);
    check("spd_160", int'(speed), 160);
    check("ground_alt", int'(altitude), 0);
    ctl(0, 0, 0, 0, 1, 0);
    ticks(1);
    check("takeoff_alt", int'(altitude), 5);
    check("takeoff_phase", int'(phase), 1);

    // Climb to the ceiling.
    ctl(1, 0, 0, 0, 1, 0);
    ticks(60);
    ctl(0, 0, 0, 0, 1, 0);
    ticks(1500);
    check("ceiling_alt", int'(altitude), 15000);
    check("ceiling_phase", int'(phase), 1);

    // Descend, bleed speed into a stall, recover, then stall to the ground.
    ctl(0, 0, 0, 0, 0, 1);
    ticks(1200);
    check("descend_alt", int'(altitude), 600);
    ctl(0, 1, 0, 0, 0, 0);
    ticks(100);
    ctl(0, 0, 0, 0, 0, 0);
    guard = 0;
    while (m_ph != 2 && guard < 400) begin ticks(1); guard++; end
    check("stall_phase", int'(phase), 2);
    a0 = m_alt;
    ctl(0, 0, 0, 0, 1, 0);
    ticks(3);
    check("stall_fall", int'(altitude), a0 - 6);
    ctl(1, 0, 0, 0, 0, 0);
    guard = 0;
    while (m_ph != 1 && guard < 200) begin ticks(1); guard++; end
    check("recover_phase", int'(phase), 1);
    ctl(0, 1, 0, 0, 0, 0);
    guard = 0;
    while (m_ph != 0 && guard < 2000) begin ticks(1); guard++; end
    check("landed_phase", int'(phase), 0);
    check("landed_alt", int'(altitude), 0);

    // Random controls and hold, sampled per cycle.
    for (int i = 0; i < 1600; i++) begin
      ctl($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
      hold = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      #1;
    end
    hold = 0;
    ticks(2);

    // Hold for ten tick periods: no updates, nothing moves.
    ctl(1, 0, 1, 0, 1, 0);
    hold = 1;
    n0 = n_upd;
    ticks(10);
    check("hold_updates", n_upd - n0, 0);
    check("hold_throttle", int'(throttle), m_thr);
    check("hold_heading", int'(heading), m_hdg);
    check("hold_altitude", int'(altitude), m_alt);
    check("hold_speed", int'(speed), m_spd);
    check("hold_phase", int'(phase), m_ph);
    hold = 0;
    ticks(5);

    // Asynchronous reset between edges.
    #1 reset_n = 1'b0;
    #1 check_zero("async_reset");
    @(negedge clk);
    #1 reset_n = 1'b1;
    ctl(1, 0, 0, 0, 0, 0);
    ticks(5);
    check("post_reset_thr", int'(throttle), 5);
    check("queue_drain", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
